// File: rtl/i2s_in_pkg.sv
// Shared constants for the I2S receive path.
package i2s_in_pkg;

   localparam int unsigned I2S_WIDTH   = 24;
   localparam logic        LR_LEFT     = 1'b0;
   localparam int unsigned SYNC_STAGES = 2;

endpackage : i2s_in_pkg

// File: rtl/i2s_sync.sv
// N-stage level synchronizer with an optional rising-edge detector on the synced output.
module i2s_sync #(
   parameter int unsigned STAGES   = 2,
   parameter bit          RISE_DET = 1'b0
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic d_i,
   output logic q_o,
   output logic rise_c
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              last_q, last_d;

   // Shift the input through the chain; keep one extra copy of the output for edge detection.
   always_comb begin
      sync_d = STAGES'({sync_q, d_i});
      last_d = sync_q[STAGES-1];
   end

   // Synchronizer and edge-history flops.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync_q <= '0;
         last_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         last_q <= last_d;
      end
   end

   assign q_o    = sync_q[STAGES-1];
   assign rise_c = RISE_DET ? (sync_q[STAGES-1] & ~last_q) : 1'b0;

endmodule : i2s_sync

// File: rtl/i2s_in.sv
// I2S slave receiver: deserializes left/right words and presents each stereo pair with a valid strobe.
module i2s_in
   import i2s_in_pkg::*;
#(
   parameter int unsigned WIDTH = I2S_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sclk,
   input  logic             lrclk,
   input  logic             sdin,
   output logic [WIDTH-1:0] l_data,
   output logic [WIDTH-1:0] r_data,
   output logic             valid,
   output logic             err
);

   localparam int unsigned NBIT_W = $clog2(WIDTH + 1);

   logic sclk_rise_c, lr_s, sd_s;
   logic sclk_lvl_unused, lr_rise_unused, sd_rise_unused;

   // Rise stage state
   logic [NBIT_W-1:0] nbit_q, nbit_d;
   logic              chan_q, chan_d;
   logic              lr_prev_q, lr_prev_d;
   logic              lr_seen_q, lr_seen_d;
   logic [WIDTH-1:0]  shift_q, shift_d;
   logic              done_q, done_d;
   logic              short_q, short_d;
   logic              slot_chan_q, slot_chan_d;
   logic              change_c;

   // Commit stage state
   logic [WIDTH-1:0]  left_buf_q, left_buf_d;
   logic              left_fresh_q, left_fresh_d;
   logic [WIDTH-1:0]  l_data_q, l_data_d;
   logic [WIDTH-1:0]  r_data_q, r_data_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;

   i2s_sync #(.STAGES(SYNC_STAGES), .RISE_DET(1'b1)) u_sclk_sync (
      .clk_i(clk), .reset_i(reset), .d_i(sclk), .q_o(sclk_lvl_unused), .rise_c(sclk_rise_c)
   );
   i2s_sync #(.STAGES(SYNC_STAGES), .RISE_DET(1'b0)) u_lrclk_sync (
      .clk_i(clk), .reset_i(reset), .d_i(lrclk), .q_o(lr_s), .rise_c(lr_rise_unused)
   );
   i2s_sync #(.STAGES(SYNC_STAGES), .RISE_DET(1'b0)) u_sdin_sync (
      .clk_i(clk), .reset_i(reset), .d_i(sdin), .q_o(sd_s), .rise_c(sd_rise_unused)
   );

   // Per sclk rise: finish the old slot's bit first, then open a new slot on an lrclk change.
   always_comb begin
      nbit_d      = nbit_q;
      chan_d      = chan_q;
      lr_prev_d   = lr_prev_q;
      lr_seen_d   = lr_seen_q;
      shift_d     = shift_q;
      done_d      = 1'b0;
      short_d     = 1'b0;
      slot_chan_d = slot_chan_q;
      change_c    = 1'b0;
      if (sclk_rise_c) begin
         lr_prev_d = lr_s;
         lr_seen_d = 1'b1;
         change_c  = lr_seen_q && (lr_s != lr_prev_q);
         if (nbit_q < NBIT_W'(WIDTH)) begin
            shift_d = {shift_q[WIDTH-2:0], sd_s};
            nbit_d  = nbit_q + NBIT_W'(1);
            if (nbit_d == NBIT_W'(WIDTH)) begin
               done_d      = 1'b1;
               slot_chan_d = chan_q;
            end
         end
         if (change_c) begin
            if (nbit_d < NBIT_W'(WIDTH)) begin
               short_d     = 1'b1;
               slot_chan_d = chan_q;
            end
            chan_d = lr_s;
            nbit_d = '0;
         end
      end
   end

   // One cycle after a completed or aborted slot: buffer left, pair on right, flag framing errors.
   always_comb begin
      left_buf_d   = left_buf_q;
      left_fresh_d = left_fresh_q;
      l_data_d     = l_data_q;
      r_data_d     = r_data_q;
      valid_d      = 1'b0;
      err_d        = 1'b0;
      if (short_q) begin
         err_d = 1'b1;
         if (slot_chan_q == LR_LEFT) left_fresh_d = 1'b0;
      end else if (done_q) begin
         if (slot_chan_q == LR_LEFT) begin
            left_buf_d   = shift_q;
            left_fresh_d = 1'b1;
         end else if (left_fresh_q) begin
            l_data_d     = left_buf_q;
            r_data_d     = shift_q;
            valid_d      = 1'b1;
            left_fresh_d = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // State registers; the bit counter idles saturated so nothing is captured before a slot change.
   always_ff @(posedge clk) begin
      if (reset) begin
         nbit_q       <= NBIT_W'(WIDTH);
         chan_q       <= 1'b0;
         lr_prev_q    <= 1'b0;
         lr_seen_q    <= 1'b0;
         shift_q      <= '0;
         done_q       <= 1'b0;
         short_q      <= 1'b0;
         slot_chan_q  <= 1'b0;
         left_buf_q   <= '0;
         left_fresh_q <= 1'b0;
         l_data_q     <= '0;
         r_data_q     <= '0;
         valid_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         nbit_q       <= nbit_d;
         chan_q       <= chan_d;
         lr_prev_q    <= lr_prev_d;
         lr_seen_q    <= lr_seen_d;
         shift_q      <= shift_d;
         done_q       <= done_d;
         short_q      <= short_d;
         slot_chan_q  <= slot_chan_d;
         left_buf_q   <= left_buf_d;
         left_fresh_q <= left_fresh_d;
         l_data_q     <= l_data_d;
         r_data_q     <= r_data_d;
         valid_q      <= valid_d;
         err_q        <= err_d;
      end
   end

   assign l_data = l_data_q;
   assign r_data = r_data_q;
   assign valid  = valid_q;
   assign err    = err_q;

endmodule : i2s_in
